// File: rtl/upstream_arb_pkg.sv
// Shared types for the upstream memory write-port arbiter.
// Holds the one-hot state encoding, the grant-source enum and the default
// address/data widths used as parameter defaults by upstream_mem_arbiter.
package upstream_arb_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 32;

    // One-hot arbiter states
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_WRITE = 4'b0010,
        ST_DONE  = 4'b0100,
        ST_ERR   = 4'b1000
    } arb_state_e;

    // Which requester owns the current write
    typedef enum logic {
        GNT_ORDER = 1'b0,
        GNT_MAX   = 1'b1
    } gnt_src_e;

endpackage

// File: rtl/upstream_mem_arbiter.sv
// Shares the single write port of the risk/limit memory between the order
// path and the max-limit path. Latches the winning request, drives the write
// handshake with an acknowledge timeout, and returns memwr / done pulses.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   order_req/addr/data, order_done   order requester, done pulse
//   max_req/addr/data, max_done       max-limit requester, done pulse
//   mem_we, mem_addr, mem_wdata, mem_ack   memory write handshake
//   memwr                         one-cycle pulse on any completed write
//   wr_err                        one-cycle pulse on acknowledge timeout
//   busy                          high whenever not IDLE
//
// Optional feature: define UPSTREAM_ARB_AGING_EN to let a long-waiting order
// request (AGE_LIMIT lost arbitrations) outrank a simultaneous max request.
// Without it, max always beats order and no age counter exists.
module upstream_mem_arbiter
    import upstream_arb_pkg::*;
#(
    parameter int unsigned AW          = AW_DEF,
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned AGE_LIMIT   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          order_req,
    input  logic [AW-1:0] order_addr,
    input  logic [DW-1:0] order_data,
    output logic          order_done,
    input  logic          max_req,
    input  logic [AW-1:0] max_addr,
    input  logic [DW-1:0] max_data,
    output logic          max_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    output logic          memwr,
    output logic          wr_err,
    output logic          busy
);

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    // Elaboration-time sanity check on the parameters
    if (ACK_TIMEOUT < 1 || AGE_LIMIT < 1) begin : g_param_check
        $error("upstream_mem_arbiter: ACK_TIMEOUT and AGE_LIMIT must be >= 1");
    end

    arb_state_e    state_q;
    gnt_src_e      grant_q;
    logic [TW-1:0] tmo_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          mem_we_q;
    logic          order_done_q;
    logic          max_done_q;
    logic          memwr_q;
    logic          wr_err_q;
    logic          busy_q;
    logic          gnt_order_c;

`ifdef UPSTREAM_ARB_AGING_EN
    localparam int unsigned AGW = $clog2(AGE_LIMIT + 1);
    logic [AGW-1:0] age_q;

    // Order wins when uncontested, or once it has aged to the limit
    always_comb begin
        gnt_order_c = order_req && !max_req;
        if (order_req && (age_q == AGW'(AGE_LIMIT))) begin
            gnt_order_c = 1'b1;
        end
    end

    // Count arbitrations lost by a waiting order request, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else if (!order_req) begin
            age_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (gnt_order_c) begin
                age_q <= '0;
            end else if (max_req && (age_q != AGW'(AGE_LIMIT))) begin
                age_q <= age_q + AGW'(1);
            end
        end
    end
`else
    // Fixed priority: a pending limit change always lands first
    always_comb begin
        gnt_order_c = order_req && !max_req;
    end
`endif

    // Arbiter FSM with registered handshake and pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_ORDER;
            tmo_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_we_q     <= 1'b0;
            order_done_q <= 1'b0;
            max_done_q   <= 1'b0;
            memwr_q      <= 1'b0;
            wr_err_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            order_done_q <= 1'b0;
            max_done_q   <= 1'b0;
            memwr_q      <= 1'b0;
            wr_err_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (order_req || max_req) begin
                        if (gnt_order_c) begin
                            grant_q <= GNT_ORDER;
                            addr_q  <= order_addr;
                            wdata_q <= order_data;
                        end else begin
                            grant_q <= GNT_MAX;
                            addr_q  <= max_addr;
                            wdata_q <= max_data;
                        end
                        tmo_q    <= '0;
                        mem_we_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Ack has precedence over a timeout on the same edge
                    if (mem_ack) begin
                        mem_we_q     <= 1'b0;
                        memwr_q      <= 1'b1;
                        order_done_q <= (grant_q == GNT_ORDER);
                        max_done_q   <= (grant_q == GNT_MAX);
                        state_q      <= ST_DONE;
                    end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                        mem_we_q <= 1'b0;
                        wr_err_q <= 1'b1;
                        state_q  <= ST_ERR;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_DONE, ST_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign order_done = order_done_q;
    assign max_done   = max_done_q;
    assign memwr      = memwr_q;
    assign wr_err     = wr_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_upstream_mem_arbiter.sv
// Directed self-checking bench for upstream_mem_arbiter (default parameters).
module tb_upstream_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        order_req;
    logic [7:0]  order_addr;
    logic [31:0] order_data;
    logic        order_done;
    logic        max_req;
    logic [7:0]  max_addr;
    logic [31:0] max_data;
    logic        max_done;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        memwr;
    logic        wr_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    upstream_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .order_req  (order_req),
        .order_addr (order_addr),
        .order_data (order_data),
        .order_done (order_done),
        .max_req    (max_req),
        .max_addr   (max_addr),
        .max_data   (max_data),
        .max_done   (max_done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .memwr      (memwr),
        .wr_err     (wr_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        order_req = 1'b0;
        max_req   = 1'b0;
        mem_ack   = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        order_req = 1'b0; order_addr = '0; order_data = '0;
        max_req = 1'b0; max_addr = '0; max_data = '0; mem_ack = 1'b0;
        tick();
        tick();
        checks++;
        if ({mem_we, order_done, max_done, memwr, wr_err, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {mem_we, order_done, max_done, memwr, wr_err, busy});
        end
        checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: got addr=%h data=%h want 00/00000000", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_order();
        mem_ack = 1'b1;
        order_addr = 8'h12; order_data = 32'hDEADBEEF; order_req = 1'b1;
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h12 || mem_wdata !== 32'hDEADBEEF || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_write: got we=%b addr=%h data=%h busy=%b want 1/12/deadbeef/1",
                     mem_we, mem_addr, mem_wdata, busy);
        end
        tick();
        checks++;
        if (order_done !== 1'b1 || memwr !== 1'b1 || max_done !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got od=%b mw=%b md=%b we=%b want 1/1/0/0",
                     order_done, memwr, max_done, mem_we);
        end
        order_req = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || memwr !== 1'b0 || order_done !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b mw=%b od=%b want 0/0/0", busy, memwr, order_done);
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        int n_memwr;
        n_memwr = 0;
        mem_ack = 1'b1;
        order_addr = 8'h01; order_data = 32'h0000_00AA;
        max_addr   = 8'h02; max_data   = 32'h0000_00BB;
        order_req = 1'b1; max_req = 1'b1;
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h02 || mem_wdata !== 32'h0000_00BB) begin
            errors++;
            $display("FAIL contend_first: got we=%b addr=%h data=%h want 1/02/000000bb",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        if (memwr === 1'b1) n_memwr++;
        checks++;
        if (max_done !== 1'b1 || order_done !== 1'b0) begin
            errors++;
            $display("FAIL contend_max_done: got md=%b od=%b want 1/0", max_done, order_done);
        end
        max_req = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h01 || mem_wdata !== 32'h0000_00AA) begin
            errors++;
            $display("FAIL contend_second: got we=%b addr=%h data=%h want 1/01/000000aa",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        if (memwr === 1'b1) n_memwr++;
        checks++;
        if (order_done !== 1'b1 || max_done !== 1'b0) begin
            errors++;
            $display("FAIL contend_order_done: got od=%b md=%b want 1/0", order_done, max_done);
        end
        order_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (memwr === 1'b1) n_memwr++;
        end
        checks++;
        if (n_memwr !== 2) begin
            errors++;
            $display("FAIL contend_memwr_count: got %0d want 2", n_memwr);
        end
        idle_inputs();
    endtask

    task automatic test_slow_memory();
        int n_we;
        int n_done;
        n_we = 0;
        n_done = 0;
        mem_ack = 1'b0;
        order_addr = 8'h34; order_data = 32'h1111_1111; order_req = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (mem_we === 1'b1) n_we++;
            checks++;
            if (mem_addr !== 8'h34 || mem_wdata !== 32'h1111_1111) begin
                errors++;
                $display("FAIL slow_latched[%0d]: got addr=%h data=%h want 34/11111111",
                         i, mem_addr, mem_wdata);
            end
            order_data = ~order_data;
            tick();
        end
        if (mem_we === 1'b1) n_we++;
        mem_ack = 1'b1;
        tick();
        if (order_done === 1'b1) n_done++;
        order_req = 1'b0;
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (order_done === 1'b1) n_done++;
            if (mem_we === 1'b1) n_we++;
        end
        checks++;
        if (n_we !== 6) begin
            errors++;
            $display("FAIL slow_we_cycles: got %0d want 6", n_we);
        end
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL slow_done_count: got %0d want 1", n_done);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int  n_we;
        int  n_memwr;
        bit  seen_err;
        n_we = 0;
        n_memwr = 0;
        seen_err = 1'b0;
        mem_ack = 1'b0;
        order_addr = 8'h55; order_data = 32'hCAFE_0001; order_req = 1'b1;
        tick();
        for (int i = 0; i < 40 && !seen_err; i++) begin
            if (wr_err === 1'b1) begin
                seen_err = 1'b1;
            end else begin
                if (mem_we === 1'b1) n_we++;
                if (memwr === 1'b1) n_memwr++;
                tick();
            end
        end
        checks++;
        if (seen_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err_seen: got %b want 1", seen_err);
        end
        checks++;
        if (n_we !== 16 || n_memwr !== 0 || mem_we !== 1'b0 || order_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cycles: got we_cycles=%0d memwr=%0d we=%b od=%b want 16/0/0/0",
                     n_we, n_memwr, mem_we, order_done);
        end
        tick();
        checks++;
        if (mem_we !== 1'b0 || wr_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got we=%b err=%b busy=%b want 0/0/0", mem_we, wr_err, busy);
        end
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h55) begin
            errors++;
            $display("FAIL timeout_regrant: got we=%b addr=%h want 1/55", mem_we, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        checks++;
        if (order_done !== 1'b1 || memwr !== 1'b1) begin
            errors++;
            $display("FAIL timeout_retry_done: got od=%b mw=%b want 1/1", order_done, memwr);
        end
        order_req = 1'b0;
        idle_inputs();
    endtask

    task automatic test_reset_mid_write();
        int n_pulse;
        n_pulse = 0;
        mem_ack = 1'b0;
        order_addr = 8'h77; order_data = 32'h7777_7777; order_req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        order_req = 1'b0;
        tick();
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_write: got we=%b busy=%b want 0/0", mem_we, busy);
        end
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if ((order_done | max_done | memwr | wr_err | mem_we) === 1'b1) n_pulse++;
            tick();
        end
        checks++;
        if (n_pulse !== 0) begin
            errors++;
            $display("FAIL rst_no_pulses: got %0d want 0", n_pulse);
        end
        idle_inputs();
    endtask

    task automatic test_aging();
        int n_od;
        int n_md;
        int exp_od;
        int exp_md;
        n_od = 0;
        n_md = 0;
`ifdef UPSTREAM_ARB_AGING_EN
        exp_od = 1;
        exp_md = 5;
`else
        exp_od = 0;
        exp_md = 6;
`endif
        mem_ack = 1'b1;
        order_addr = 8'h0A; max_addr = 8'h0B;
        order_req = 1'b1; max_req = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (order_done === 1'b1) n_od++;
            if (max_done === 1'b1) n_md++;
        end
        checks++;
        if (n_od !== exp_od || n_md !== exp_md) begin
            errors++;
            $display("FAIL aging_grants: got order=%0d max=%0d want order=%0d max=%0d",
                     n_od, n_md, exp_od, exp_md);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_order();
        test_contention();
        test_slow_memory();
        test_timeout();
        test_reset_mid_write();
        test_aging();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/upstream_mem_arbiter.md
Name: upstream_mem_arbiter

Overview:
- Shares the single write port of the clocked risk/limit memory between two requesters: the order path (driven from send_order) and the max-limit path (driven from update_max).
- Latches the winning request and drives the memory write handshake, with a timeout on the acknowledge.
- Returns a one-cycle memwr pulse to the upstream order FSM, plus a per-requester done pulse.

Parameters:
- AW, 8: memory address width.
- DW, 32: memory data width.
- ACK_TIMEOUT, 16: cycles in WRITE without mem_ack before the write is aborted; must be >= 1.
- AGE_LIMIT, 4: used only with the optional feature; wait cycles after which a pending order request outranks a max request.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- order_req  in  1  order write request; held high until order_done.
- order_addr  in  AW  order write address; stable while order_req is high.
- order_data  in  DW  order write data; stable while order_req is high.
- order_done  out  1  one-cycle pulse: order write completed.
- max_req  in  1  max-limit write request; held high until max_done.
- max_addr  in  AW  max-limit write address.
- max_data  in  DW  max-limit write data.
- max_done  out  1  one-cycle pulse: max-limit write completed.
- mem_we  out  1  memory write enable; held until acknowledged.
- mem_addr  out  AW  registered write address.
- mem_wdata  out  DW  registered write data.
- mem_ack  in  1  memory accepted the write; sampled only in WRITE.
- memwr  out  1  one-cycle pulse to the upstream FSM on any completed write.
- wr_err  out  1  one-cycle pulse on write timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE. mem_we, order_done, max_done, memwr, wr_err and busy are 0. mem_addr=0, mem_wdata=0, timeout and age counters = 0.
- Reset mid-operation: reset wins over everything. Return to IDLE next edge; mem_we drops with no done or memwr pulse. The requester re-issues.
- States: IDLE, WRITE, DONE, ERR (one-hot).
- IDLE, no request: stay in IDLE.
- IDLE, any request at an edge:
  - choose the winner: max_req beats order_req (fixed priority; a limit change must land before further orders are sent);
  - latch the winner's address and data into mem_addr/mem_wdata;
  - record the source in a grant register; clear the timeout counter; go to WRITE.
- WRITE:
  - mem_we=1; address and data come from the latched registers, not live inputs;
  - timeout counter increments each cycle without mem_ack;
  - mem_ack=1 -> DONE;
  - counter reaches ACK_TIMEOUT-1 with mem_ack=0 -> ERR;
  - mem_ack and timeout on the same edge -> ack wins, go to DONE.
- DONE: one cycle. memwr=1; the granted source's done=1, the other done=0. Then go to IDLE.
- ERR: one cycle. wr_err=1; neither done pulses, memwr=0. Then go to IDLE; the request is still pending and is re-arbitrated.
- Latency: req sampled at edge N gives mem_we high in cycle N+1. With mem_ack in that same cycle, memwr and done are high in cycle N+2.
  - Minimum 3 cycles per write (IDLE, WRITE, DONE); back-to-back throughput is one write per 3 cycles.
- A request dropped during WRITE is ignored; the latched write completes and the done pulse still fires.
- mem_ack outside WRITE is ignored.
- Requesters drop req on the edge that ends their done cycle, so the following IDLE does not re-grant them.

Optional Feature:
- Macro: UPSTREAM_ARB_AGING_EN.
- Defined:
  - the age counter increments every IDLE-arbitration cycle in which order_req is high and max wins;
  - it saturates at AGE_LIMIT and clears when order is granted or order_req is low;
  - at AGE_LIMIT, order wins over a simultaneous max_req.
- Undefined: strict max-over-order priority; no age counter is synthesized.

Decomposition:
- Package upstream_arb_pkg holds:
  - the state encoding constants (IDLE/WRITE/DONE/ERR, one-hot, 4 bits);
  - the grant-source enum (GNT_ORDER, GNT_MAX);
  - default widths AW_DEF=8 and DW_DEF=32.
- The timeout counter, age counter and arbitration logic are inline; no sub-module is warranted.

Test Plan:
- Single order: order_req=1, addr=0x12, data=0xDEADBEEF; mem_ack tied high -> mem_we in cycle N+1 with mem_addr=0x12 and mem_wdata=0xDEADBEEF; order_done=1 and memwr=1 in N+2; max_done stays 0.
- Contention: order_req and max_req rise together (order addr 0x01, max addr 0x02) -> first write goes to 0x02 with max_done; second write goes to 0x01 with order_done; exactly 2 memwr pulses.
- Slow memory: mem_ack delayed 5 cycles -> mem_we held 6 cycles; mem_addr/mem_wdata unchanged even though order_data toggles; a single done pulse.
- Timeout: mem_ack held 0 with ACK_TIMEOUT=16 -> wr_err pulse after 16 WRITE cycles; no memwr; the still-pending request is re-granted 2 cycles later.
- Reset mid-write: rst=1 in the 2nd WRITE cycle -> next cycle mem_we=0, busy=0, no done, memwr or wr_err pulse ever issued for that write.
- Aging (UPSTREAM_ARB_AGING_EN, AGE_LIMIT=4): order_req held while max_req re-asserts every cycle -> order granted on the 5th arbitration. Without the macro, order is never granted while max_req stays high.
